// File: rtl/mips_instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder / IM loader.
// Contents: opcode and funct values (the same ones the control decoder recognises),
// the 5-bit mnemonic codes accepted on in_code, the FSM state encodings and the
// packed request/result payloads.
package mips_instr_encoder_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAS   = 6'b110110;

    // R-type funct field
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // Mnemonic codes on in_code; 18..31 are undefined
    localparam logic [4:0] CODE_ADD  = 5'd0;
    localparam logic [4:0] CODE_SUB  = 5'd1;
    localparam logic [4:0] CODE_ADDU = 5'd2;
    localparam logic [4:0] CODE_SUBU = 5'd3;
    localparam logic [4:0] CODE_SLL  = 5'd4;
    localparam logic [4:0] CODE_JR   = 5'd5;
    localparam logic [4:0] CODE_JALR = 5'd6;
    localparam logic [4:0] CODE_ORI  = 5'd7;
    localparam logic [4:0] CODE_LW   = 5'd8;
    localparam logic [4:0] CODE_SW   = 5'd9;
    localparam logic [4:0] CODE_BEQ  = 5'd10;
    localparam logic [4:0] CODE_LUI  = 5'd11;
    localparam logic [4:0] CODE_LB   = 5'd12;
    localparam logic [4:0] CODE_LH   = 5'd13;
    localparam logic [4:0] CODE_SB   = 5'd14;
    localparam logic [4:0] CODE_SH   = 5'd15;
    localparam logic [4:0] CODE_ADDI = 5'd16;
    localparam logic [4:0] CODE_JAS  = 5'd17;

    // Loader FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  shamt;
        logic [IMM_W-1:0]  imm;
    } instr_req_t;

    typedef struct packed {
        logic               bad;
        logic [INSTR_W-1:0] word;
    } enc_result_t;

endpackage

// File: rtl/mips_instr_encoder_sync_fifo.sv
// Synchronous FIFO buffering encoded words between the request side and IM.
// Ports: clk, reset (sync, active-high), push/wdata (write), pop (read),
//        head_c (current head word), full_c, empty_c.
// Callers must not push when full nor pop when empty.
module mips_instr_encoder_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset; contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
        end
    end

    assign head_c  = mem[rd_ptr[PTR_W-1:0]];
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder and IM program loader.
// Turns mnemonic-level requests into 32-bit machine words, buffers them and streams
// them into instruction memory at consecutive word addresses starting at base_addr.
// Ports: clk, reset (sync, active-high); start/base_addr begin a load;
//        in_valid/in_ready/in_* request handshake with in_last marking the final one;
//        im_stall back-pressure from IM; im_we/im_addr/im_wdata registered IM write;
//        done, bad_code (sticky undefined code), wrapped (sticky address wrap).
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_shamt,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic               in_last,
    input  logic               im_stall,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               done,
    output logic               bad_code,
    output logic               wrapped
);

    // Mnemonic to machine word; unused fields of each format are forced to zero
    function automatic enc_result_t encode(input instr_req_t r);
        enc_result_t e;
        e.bad  = 1'b0;
        e.word = '0;
        case (r.code)
            CODE_ADD:  e.word = {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_ADD};
            CODE_SUB:  e.word = {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_SUB};
            CODE_ADDU: e.word = {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_ADDU};
            CODE_SUBU: e.word = {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, FN_SUBU};
            CODE_SLL:  e.word = {OP_RTYPE, 5'd0, r.rt, r.rd, r.shamt, FN_SLL};
            CODE_JR:   e.word = {OP_RTYPE, r.rs, 5'd0, 5'd0, 5'd0, FN_JR};
            CODE_JALR: e.word = {OP_RTYPE, r.rs, 5'd0, r.rd, 5'd0, FN_JALR};
            CODE_ORI:  e.word = {OP_ORI,  r.rs, r.rt, r.imm};
            CODE_LW:   e.word = {OP_LW,   r.rs, r.rt, r.imm};
            CODE_SW:   e.word = {OP_SW,   r.rs, r.rt, r.imm};
            CODE_BEQ:  e.word = {OP_BEQ,  r.rs, r.rt, r.imm};
            CODE_LUI:  e.word = {OP_LUI,  5'd0, r.rt, r.imm};
            CODE_LB:   e.word = {OP_LB,   r.rs, r.rt, r.imm};
            CODE_LH:   e.word = {OP_LH,   r.rs, r.rt, r.imm};
            CODE_SB:   e.word = {OP_SB,   r.rs, r.rt, r.imm};
            CODE_SH:   e.word = {OP_SH,   r.rs, r.rt, r.imm};
            CODE_ADDI: e.word = {OP_ADDI, r.rs, r.rt, r.imm};
            CODE_JAS:  e.word = {OP_JAS,  r.rs, r.rt, r.imm};
            default:   e.bad  = 1'b1;
        endcase
        return e;
    endfunction

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    addr_inc;
    instr_req_t         req;
    enc_result_t        enc;
    logic               push;
    logic               pop;
    logic               start_take;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_head;

    assign req = '{code: in_code, rs: in_rs, rt: in_rt, rd: in_rd,
                   shamt: in_shamt, imm: in_imm};
    assign enc = encode(req);

    // Full FIFO refuses input even if it pops this cycle
    assign in_ready   = (state_q == ST_LOAD) && !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && !im_stall;
    assign start_take = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign addr_inc   = {1'b0, addr_q} + (ADDR_W + 1)'(4);

    mips_instr_encoder_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wdata   (enc.word),
        .pop     (pop),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN exits once the last word has been popped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (push && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // IM write port, address counter and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            done     <= 1'b0;
            bad_code <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            im_we <= pop;
            done  <= (state_d == ST_DONE);
            if (pop) begin
                im_addr  <= addr_q;
                im_wdata <= fifo_head;
                addr_q   <= addr_inc[ADDR_W-1:0];
                if (addr_inc[ADDR_W]) begin
                    wrapped <= 1'b1;
                end
            end
            if (push && enc.bad) begin
                bad_code <= 1'b1;
            end
            // FIFO is empty in IDLE/DONE, so a new load never collides with a pop
            if (start_take) begin
                addr_q   <= base_addr & ~ADDR_W'(3);
                bad_code <= 1'b0;
                wrapped  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed programs plus randomized
// programs checked against an arithmetic reference encoder and address model.
module tb_mips_instr_encoder;

    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int ASPACE     = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_code;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              im_stall;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              done;
    logic              bad_code;
    logic              wrapped;

    mips_instr_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .im_stall  (im_stall),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .done      (done),
        .bad_code  (bad_code),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stall source: either a held level or a random pattern
    logic rand_stall = 1'b0;
    logic stall_hold = 1'b0;
    logic rnd_bit    = 1'b0;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) == 0);
    assign im_stall = rand_stall ? rnd_bit : stall_hold;

    // Record every IM write
    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t wq[$];
    always @(negedge clk) begin
        if (im_we === 1'b1) wq.push_back('{int'(im_addr), im_wdata, cyc});
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cyc;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Reference encoder: field values placed by weight, per mnemonic rules
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
        longint w;
        w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn);
        return 32'(w);
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        longint w;
        w = longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        return 32'(w);
    endfunction

    function automatic logic [31:0] ref_word(input int code, input int rs, input int rt, input int rd,
                                             input int sh, input int imm);
        case (code)
            0:  return rtype(rs, rt, rd, 0, 32);
            1:  return rtype(rs, rt, rd, 0, 34);
            2:  return rtype(rs, rt, rd, 0, 33);
            3:  return rtype(rs, rt, rd, 0, 35);
            4:  return rtype(0, rt, rd, sh, 0);
            5:  return rtype(rs, 0, 0, 0, 8);
            6:  return rtype(rs, 0, rd, 0, 9);
            7:  return itype(13, rs, rt, imm);
            8:  return itype(35, rs, rt, imm);
            9:  return itype(43, rs, rt, imm);
            10: return itype(4, rs, rt, imm);
            11: return itype(15, 0, rt, imm);
            12: return itype(32, rs, rt, imm);
            13: return itype(33, rs, rt, imm);
            14: return itype(40, rs, rt, imm);
            15: return itype(41, rs, rt, imm);
            16: return itype(8, rs, rt, imm);
            17: return itype(54, rs, rt, imm);
            default: return 32'h0;
        endcase
    endfunction

    task automatic start_prog(input int base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        @(negedge clk);
        start = 1'b0;
        wq.delete();
        exp_q.delete();
    endtask

    // Present one request and wait (bounded) for acceptance
    task automatic send(input int code, input int rs, input int rt, input int rd, input int sh,
                        input int imm, input bit last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 5'(code);
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_shamt = 5'(sh);
        in_imm   = 16'(imm);
        in_last  = last;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", code, 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic finish_prog();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        #1;
        chk("done", 0, 32'(done), 32'd1);
    endtask

    // Compare captured writes with the expected words at consecutive addresses
    task automatic check_prog(input string tag, input int base, input bit exp_bad);
        int  base_al = base & ~3;
        bit  exp_wrap = (base_al + 4 * exp_q.size()) >= ASPACE;
        chk({tag, "_count"}, 0, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            chk({tag, "_addr"}, i, 32'(wq[i].a), 32'((base_al + 4 * i) % ASPACE));
            chk({tag, "_data"}, i, wq[i].d, exp_q[i]);
        end
        if (wq.size() > 0) chk({tag, "_done_lat"}, 0, 32'(done_cyc), 32'(wq[wq.size() - 1].c + 1));
        chk({tag, "_bad"}, 0, 32'(bad_code), 32'(exp_bad));
        chk({tag, "_wrap"}, 0, 32'(wrapped), 32'(exp_wrap));
    endtask

    initial begin
        int base, n, code, rs, rt, rd, sh, imm;
        bit ebad;
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_code = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_last = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
        chk("rst_im_we", 0, 32'(im_we), 32'd0);
        chk("rst_im_addr", 0, 32'(im_addr), 32'd0);
        chk("rst_im_wdata", 0, im_wdata, 32'd0);
        chk("rst_flags", 0, {29'd0, done, bad_code, wrapped}, 32'd0);
        reset = 1'b0;

        // add $3,$1,$2
        start_prog(0);
        send(0, 1, 2, 3, 0, 0, 1'b1);
        finish_prog();
        exp_q.push_back(32'h0022_1820);
        check_prog("add", 0, 1'b0);
        chk("done_ready", 0, 32'(in_ready), 32'd0);

        // ori / lw / sll (sll rs supplied non-zero, must be dropped)
        start_prog(0);
        chk("start_clears_done", 0, 32'(done), 32'd0);
        send(7, 0, 1, 0, 0, 16'h1234, 1'b0);
        send(8, 1, 2, 0, 0, 8, 1'b0);
        send(4, 7, 2, 4, 3, 0, 1'b1);
        finish_prog();
        exp_q.push_back(32'h3401_1234);
        exp_q.push_back(32'h8C22_0008);
        exp_q.push_back(32'h0002_20C0);
        check_prog("ori_lw_sll", 0, 1'b0);

        // jas then undefined code
        start_prog(0);
        send(17, 0, 0, 0, 0, 0, 1'b0);
        send(31, 5, 6, 7, 8, 16'hBEEF, 1'b1);
        finish_prog();
        exp_q.push_back(32'hD800_0000);
        exp_q.push_back(32'h0000_0000);
        check_prog("jas_bad", 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("bad_sticky", 0, 32'(bad_code), 32'd1);

        // Stalled IM: FIFO fills after FIFO_DEPTH accepts
        stall_hold = 1'b1;
        start_prog(12'h200);
        chk("bad_cleared", 0, 32'(bad_code), 32'd0);
        for (int i = 0; i < 4; i++) begin
            code = $urandom_range(0, 17); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
            rd = $urandom_range(0, 31); sh = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
            exp_q.push_back(ref_word(code, rs, rt, rd, sh, imm));
            send(code, rs, rt, rd, sh, imm, 1'b0);
        end
        @(negedge clk);
        chk("full_ready", 5, 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("full_ready", 6, 32'(in_ready), 32'd0);
        chk("stall_no_write", 0, 32'(wq.size()), 32'd0);
        stall_hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            code = $urandom_range(0, 17); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
            rd = $urandom_range(0, 31); sh = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
            exp_q.push_back(ref_word(code, rs, rt, rd, sh, imm));
            send(code, rs, rt, rd, sh, imm, i == 1);
        end
        finish_prog();
        check_prog("stall", 12'h200, 1'b0);

        // Address wrap at top of IM
        start_prog(ASPACE - 4);
        send(16, 1, 2, 0, 0, 16'hFFFF, 1'b0);
        send(11, 9, 3, 0, 0, 16'h8000, 1'b1);
        finish_prog();
        exp_q.push_back(32'h2022_FFFF);
        exp_q.push_back(32'h3C03_8000);
        check_prog("wrap", ASPACE - 4, 1'b0);

        // Randomized programs with random IM stalls
        for (int p = 0; p < 6; p++) begin
            base = (p == 0) ? (ASPACE - 9) : int'($urandom_range(0, ASPACE - 1));
            n = $urandom_range(1, 8);
            ebad = 1'b0;
            rand_stall = 1'b1;
            start_prog(base);
            for (int i = 0; i < n; i++) begin
                code = $urandom_range(0, 19); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
                rd = $urandom_range(0, 31); sh = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
                exp_q.push_back(ref_word(code, rs, rt, rd, sh, imm));
                if (code > 17) ebad = 1'b1;
                send(code, rs, rt, rd, sh, imm, i == n - 1);
            end
            finish_prog();
            check_prog("rnd", base, ebad);
            rand_stall = 1'b0;
        end

        // Reset while draining: buffered words are discarded
        stall_hold = 1'b1;
        start_prog(12'h100);
        send(0, 1, 2, 3, 0, 0, 1'b0);
        send(1, 4, 5, 6, 0, 0, 1'b0);
        send(2, 7, 8, 9, 0, 0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_drain_we", 0, 32'(im_we), 32'd0);
        chk("rst_drain_ready", 0, 32'(in_ready), 32'd0);
        chk("rst_drain_done", 0, 32'(done), 32'd0);
        reset      = 1'b0;
        stall_hold = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("rst_drain_nowrite", 0, 32'(wq.size()), 32'd0);
        chk("rst_drain_idle", 0, 32'(in_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
